// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational 8-bit ALU among NREQ requesters.
// Define ALU_ARB_ERR_EN to flag opcodes 110/111 as illegal and suppress their result.
module alu_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   a_in,
  input  logic [8*NREQ-1:0]   b_in,
  input  logic [3*NREQ-1:0]   op_in,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [2:0]          alu_op,
  input  logic [7:0]          alu_result,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           op_illegal;

  logic [7:0] a_arr  [NREQ];
  logic [7:0] b_arr  [NREQ];
  logic [2:0] op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = a_in[8*i +: 8];
    assign b_arr[i]  = b_in[8*i +: 8];
    assign op_arr[i] = op_in[3*i +: 3];
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (rst_n && state == IDLE && win_found) gnt[win_idx] = 1'b1;
  end

`ifdef ALU_ARB_ERR_EN
  assign op_illegal = alu_op[2] & alu_op[1];
`else
  assign op_illegal = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= IDW'(NREQ - 1);
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            alu_a  <= a_arr[win_idx];
            alu_b  <= b_arr[win_idx];
            alu_op <= op_arr[win_idx];
            rsp_id <= win_idx;
            last   <= win_idx;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= op_illegal ? 8'd0 : alu_result;
          rsp_zero   <= op_illegal ? 1'b0 : alu_zero;
          rsp_err    <= op_illegal;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU and response scoreboard.
// Honours ALU_ARB_ERR_EN for the illegal-opcode expectations.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] a_in;
  logic [8*NREQ-1:0] b_in;
  logic [3*NREQ-1:0] op_in;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_op;
  logic [7:0]        alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_result;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     result;
    logic           zero;
    logic           err;
  } rsp_t;

  rsp_t            sb[$];
  rsp_t            obs[$];
  logic [NREQ-1:0] glog[$];
  int              gcyc[$];
  int              obs_rd = 0;
  int              ncyc = 0;
  int              compared = 0;
  int              mismatched = 0;
  logic            hold_req = 1'b0;
  logic [NREQ-1:0] pend = '0;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a | b);
      default: r = 8'd0;
    endcase
    return {r == 8'd0, r};
  endfunction

  assign {alu_zero, alu_result} = alu_model(alu_a, alu_b, alu_op);

  // Records raw grants and every accepted response, away from the rising edge.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    pend = gnt & req;
    if (|gnt) begin
      glog.push_back(gnt);
      gcyc.push_back(ncyc);
    end
    if (rsp_valid && rsp_ready) obs.push_back({rsp_id, rsp_result, rsp_zero, rsp_err});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (!hold_req) req = req & ~pend;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op);
    a_in[8*i +: 8]  = a;
    b_in[8*i +: 8]  = b;
    op_in[3*i +: 3] = op;
    req[i]          = 1'b1;
  endtask

  task automatic expectRsp(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
    rsp_t       e;
    logic [8:0] zr;
    zr       = alu_model(a, b, op);
    e.id     = IDW'(i);
    e.result = zr[7:0];
    e.zero   = zr[8];
    e.err    = 1'b0;
`ifdef ALU_ARB_ERR_EN
    if (op[2] & op[1]) begin
      e.result = 8'd0;
      e.zero   = 1'b0;
      e.err    = 1'b1;
    end
`endif
    sb.push_back(e);
  endtask

  task automatic waitResponses(input string tag, input int target, input int budget);
    for (int n = 0; n < budget && obs.size() < target; n++) step();
    checkOutput({"timeout_", tag}, 32'(obs.size() >= target), 32'd1);
  endtask

  task automatic checkResponses();
    rsp_t e;
    while (obs_rd < obs.size()) begin
      e = (sb.size() > 0) ? sb.pop_front() : rsp_t'('x);
      checkOutput($sformatf("rsp%0d", obs_rd), 32'(obs[obs_rd]), 32'(e));
      obs_rd++;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"},        32'(gnt),        32'd0);
    checkOutput({tag, "_alu_a"},      32'(alu_a),      32'd0);
    checkOutput({tag, "_alu_b"},      32'(alu_b),      32'd0);
    checkOutput({tag, "_alu_op"},     32'(alu_op),     32'd0);
    checkOutput({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    checkOutput({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
    checkOutput({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    checkOutput({tag, "_rsp_zero"},   32'(rsp_zero),   32'd0);
    checkOutput({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    checkOutput({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    int g0;
    int o0;
    logic [NREQ-1:0] seq3 [4];
    seq3[0] = 4'b0010; seq3[1] = 4'b1000; seq3[2] = 4'b0010; seq3[3] = 4'b1000;

    rst_n = 1'b1; req = '0; a_in = '0; b_in = '0; op_in = '0; rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    sample();
    checkAllZero("reset");
    step();
    rst_n = 1'b1;

    // Single add: grant same cycle, response two cycles later.
    step();
    applyStimulus(0, 8'd8, 8'd4, 3'b000);
    expectRsp(0, 8'd8, 8'd4, 3'b000);
    sample();
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);
    step(); sample();
    checkOutput("t1_exec_busy", 32'(busy), 32'd1);
    checkOutput("t1_alu_a", 32'(alu_a), 32'd8);
    checkOutput("t1_alu_b", 32'(alu_b), 32'd4);
    checkOutput("t1_alu_op", 32'(alu_op), 32'd0);
    checkOutput("t1_exec_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t1_exec_gnt", 32'(gnt), 32'd0);
    step(); sample();
    checkOutput("t1_valid", 32'(rsp_valid), 32'd1);
    checkOutput("t1_id", 32'(rsp_id), 32'd0);
    checkOutput("t1_result", 32'(rsp_result), 32'd12);
    checkOutput("t1_zero", 32'(rsp_zero), 32'd0);
    step(); sample();
    checkOutput("t1_done_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t1_done_busy", 32'(busy), 32'd0);
    checkResponses();

    // Four simultaneous requests after reset: order 0..3, three cycles apart.
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    step();
    g0 = glog.size();
    o0 = obs.size();
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 8'd5, 8'd5, 3'b001);
      expectRsp(i, 8'd5, 8'd5, 3'b001);
    end
    waitResponses("t2", o0 + 4, 40);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_gnt%0d", k), 32'(glog[g0+k]), 32'(4'b0001 << k));
      if (k > 0) checkOutput($sformatf("t2_gap%0d", k), 32'(gcyc[g0+k] - gcyc[g0+k-1]), 32'd3);
    end
    checkResponses();

    // Requesters 1 and 3 held continuously alternate.
    step();
    g0 = glog.size();
    o0 = obs.size();
    hold_req = 1'b1;
    applyStimulus(1, 8'h0F, 8'hF0, 3'b011);
    applyStimulus(3, 8'h00, 8'h00, 3'b011);
    for (int k = 0; k < 2; k++) begin
      expectRsp(1, 8'h0F, 8'hF0, 3'b011);
      expectRsp(3, 8'h00, 8'h00, 3'b011);
    end
    for (int n = 0; n < 30 && glog.size() < g0 + 4; n++) step();
    req = '0;
    hold_req = 1'b0;
    checkOutput("t3_grant_count", 32'(glog.size() - g0), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t3_gnt%0d", k), 32'(glog[g0+k]), 32'(seq3[k]));
    waitResponses("t3", o0 + 4, 30);
    checkResponses();

    // Consumer stall: response held, no grant while stalled.
    step();
    o0 = obs.size();
    rsp_ready = 1'b0;
    applyStimulus(2, 8'd200, 8'd100, 3'b000);
    expectRsp(2, 8'd200, 8'd100, 3'b000);
    sample();
    checkOutput("t4_gnt2", 32'(gnt), 32'h4);
    step();
    applyStimulus(1, 8'd0, 8'd1, 3'b001);
    expectRsp(1, 8'd0, 8'd1, 3'b001);
    for (int k = 0; k < 5; k++) begin
      step(); sample();
      checkOutput($sformatf("t4_valid%0d", k), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("t4_id%0d", k), 32'(rsp_id), 32'd2);
      checkOutput($sformatf("t4_result%0d", k), 32'(rsp_result), 32'd44);
      checkOutput($sformatf("t4_gnt%0d", k), 32'(gnt), 32'd0);
      checkOutput($sformatf("t4_busy%0d", k), 32'(busy), 32'd1);
    end
    step();
    rsp_ready = 1'b1;
    step(); sample();
    checkOutput("t4_idle_busy", 32'(busy), 32'd0);
    checkOutput("t4_idle_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t4_next_gnt", 32'(gnt), 32'h2);
    waitResponses("t4", o0 + 2, 20);
    checkResponses();

    // Reset during EXEC drops the operation; pointer returns to requester 0 first.
    step();
    applyStimulus(1, 8'd255, 8'd1, 3'b000);
    sample();
    checkOutput("t5_gnt1", 32'(gnt), 32'h2);
    step();
    o0 = obs.size();
    rst_n = 1'b0;
    applyStimulus(2, 8'hAA, 8'h55, 3'b100);
    applyStimulus(0, 8'h80, 8'h80, 3'b000);
    sample();
    checkAllZero("t5_rst");
    step(); sample();
    checkOutput("t5_rst_hold_gnt", 32'(gnt), 32'd0);
    checkOutput("t5_no_rsp", 32'(obs.size()), 32'(o0));
    step();
    rst_n = 1'b1;
    expectRsp(0, 8'h80, 8'h80, 3'b000);
    expectRsp(2, 8'hAA, 8'h55, 3'b100);
    sample();
    checkOutput("t5_gnt0_first", 32'(gnt), 32'h1);
    waitResponses("t5", o0 + 2, 20);
    checkResponses();

    // Illegal opcode handling.
    step();
    o0 = obs.size();
    applyStimulus(3, 8'd3, 8'd3, 3'b110);
    expectRsp(3, 8'd3, 8'd3, 3'b110);
    waitResponses("t6", o0 + 1, 10);
`ifdef ALU_ARB_ERR_EN
    checkOutput("t6_illegal", 32'({obs[o0].result, obs[o0].zero, obs[o0].err}), 32'h001);
`else
    checkOutput("t6_illegal", 32'({obs[o0].result, obs[o0].zero, obs[o0].err}), 32'h002);
`endif
    checkResponses();

    // AND and NOR paths.
    step();
    o0 = obs.size();
    applyStimulus(0, 8'hF0, 8'h3C, 3'b010);
    applyStimulus(1, 8'hF0, 8'h0F, 3'b101);
    expectRsp(0, 8'hF0, 8'h3C, 3'b010);
    expectRsp(1, 8'hF0, 8'h0F, 3'b101);
    waitResponses("t7", o0 + 2, 20);
    checkOutput("t7_and", 32'(obs[o0].result), 32'h30);
    checkOutput("t7_nor_zero", 32'(obs[o0+1].zero), 32'd1);
    checkResponses();

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU (add, sub, and, or, xor, nor; opcodes 000-101) among NREQ requesters. It accepts one operation at a time through a req/gnt handshake and registers the operands into the ALU. It then captures the ALU result and zero flag and returns them with the requester ID through a valid/ready response port. It sits between the agrobot control clients and the shared ALU instance.

## Interface
- NREQ, 4: number of requesters, 2..8; ID width IDW = $clog2(NREQ)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester operation request
- a_in  in  8*NREQ  packed operand A, requester i at [8i+7:8i]
- b_in  in  8*NREQ  packed operand B, same packing
- op_in  in  3*NREQ  packed opcode, requester i at [3i+2:3i]
- gnt  out  NREQ  one-hot grant; transfer when req[i] && gnt[i] at a rising edge
- alu_a, alu_b  out  8  registered operands to shared ALU
- alu_op  out  3  registered opcode to shared ALU
- alu_result  in  8  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  index of requester that issued the operation
- rsp_result  out  8  captured result
- rsp_zero  out  1  captured zero flag
- rsp_err  out  1  illegal opcode flag (see Configuration)
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req bit is set, pick the winner round-robin, starting at (last + 1) mod NREQ. Drive gnt combinationally for that index only. At the edge, latch a/b/op of the winner into alu_a/alu_b/alu_op, latch the winner into rsp_id and last, and go to EXEC. gnt is 0 in every other state.
- EXEC: the ALU is driven from registers. At the edge, capture alu_result/alu_zero (and the error check) into the rsp_* registers, then go to RESP.
- RESP: rsp_valid=1. Hold rsp_* stable until rsp_valid && rsp_ready at an edge, then clear rsp_valid and go to IDLE. No grant is issued in the handshake cycle.
- Requesters hold req and operands stable until granted. Dropping req before a grant withdraws the request with no side effect.
- alu_a/alu_b/alu_op keep their last values outside EXEC.
- Arithmetic: 8-bit modulo, passed through from the ALU unchanged. 255+1 gives 0 with zero=1; 0-1 gives 255.
- The last pointer resets to NREQ-1, so requester 0 has first priority after reset.
- Reset (async, any state, including mid-EXEC or RESP): state=IDLE, last=NREQ-1. gnt, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err and busy all go to 0 immediately. The in-flight operation is dropped and its requester must re-request.

## Timing
- Grant in cycle N (IDLE). EXEC in cycle N+1. rsp_valid rises at the start of N+2, so latency is 2 cycles from accept to response.
- With rsp_ready held high: RESP lasts 1 cycle, IDLE is re-entered at N+3, and the next grant can occur at N+3. Maximum throughput is 1 operation per 3 cycles.
- rsp_ready low stalls in RESP indefinitely. No new grant is issued while stalled.
- gnt has a combinational path from req in IDLE. All other outputs are registered.

## Configuration
- ALU_ARB_ERR_EN defined: an opcode of 110 or 111 sets rsp_err=1 and forces rsp_result=0 and rsp_zero=0; the ALU output is ignored. Legal opcodes give rsp_err=0.
- ALU_ARB_ERR_EN undefined: rsp_err is tied to 0. Illegal opcodes pass the ALU output through (result 0, zero 1).

## Test plan
- Single operation: req[0], A=8, B=4, op=000 -> gnt[0] in the same cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- All four requesters request after reset, each with A=5, B=5, op=001 -> grants in order 0,1,2,3, each 3 cycles apart; every response gives result 0, zero 1.
- req[1] and req[3] held continuously with op=011 -> grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
- rsp_ready held low for 5 cycles after rsp_valid -> rsp_valid and rsp_* stay stable, gnt stays 0, busy stays 1; on release, IDLE is entered the next cycle.
- rst_n pulsed low during EXEC -> all outputs are 0 immediately with no response issued; after release, a held req[2] and req[0] give gnt[0] first.
- op=110 with A=3, B=3 -> with ALU_ARB_ERR_EN: rsp_err=1, result 0, zero 0; without it: rsp_err=0, result 0, zero 1.
